reg_op_sequencer: RTL
=====================

Name: reg_op_sequencer

Overview:
- Controller that shares one 4-bit shift/count register between two requesters and sequences its control strobes (cl, ld, inc, dec, sr, sl).
- Each requester submits a command (opcode, load data, serial bit, repeat count) over a valid/ready handshake.
- The block grants one requester at a time using round-robin arbitration, emits one register strobe per cycle for the repeat count, then pulses done to the owner.
- Sits between bus-side requesters and the register instance; it owns all of the register's control inputs.

Parameters:
DW, 4, register data width (load data / in bus)
CNT_W, 3, repeat-count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
vld0  input  1  requester 0 command valid
op0  input  3  requester 0 opcode
dat0  input  DW  requester 0 load data
sb0  input  1  requester 0 serial-in bit for shifts
cnt0  input  CNT_W  requester 0 repeat count
rdy0  output  1  requester 0 command accepted this cycle
done0  output  1  requester 0 command complete pulse
vld1/op1/dat1/sb1/cnt1/rdy1/done1  as above for requester 1
r_cl  output  1  register clear strobe
r_ld  output  1  register load strobe
r_in  output  DW  register load data
r_inc  output  1  register increment strobe
r_dec  output  1  register decrement strobe
r_sr  output  1  register shift-right strobe
r_ir  output  1  register shift-right serial in
r_sl  output  1  register shift-left strobe
r_il  output  1  register shift-left serial in
busy  output  1  command in execution

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Opcodes:
  - 0 NOP
  - 1 CLR
  - 2 LOAD
  - 3 INC
  - 4 DEC
  - 5 SHR
  - 6 SHL
  - 7 reserved, treated as NOP
- Reset (rst=1 at clk edge):
  - state=IDLE, rr pointer=0.
  - All outputs 0: rdy*, done*, all r_* strobes, r_in, busy.
  - Reset mid-command abandons it with no done pulse.
- States: IDLE, EXEC.
- IDLE:
  - Arbitration is combinational on vld0/vld1. If exactly one is valid, it is granted. If both are valid, the requester selected by rr is granted.
  - rdyN=1 only for the granted requester, and only in IDLE.
  - On handshake (vldN&rdyN), the block latches op, dat, sb and cnt, and the owner; state goes to EXEC; rr is set to the other requester.
  - rdy* are 0 in EXEC.
- Effective length L:
  - CLR, LOAD and NOP: L=1, count ignored.
  - INC, DEC, SHR and SHL: L=cnt, with cnt=0 treated as 1. Maximum L is 2^CNT_W-1.
- EXEC:
  - Strobes are registered outputs and begin the cycle after the handshake.
  - Exactly one strobe is asserted per cycle for L consecutive cycles (NOP asserts none for 1 cycle).
  - r_in=latched dat and is valid while r_ld=1; otherwise r_in=0.
  - r_ir=sb during SHR cycles, r_il=sb during SHL cycles; both 0 otherwise.
  - At most one of r_cl/r_ld/r_inc/r_dec/r_sr/r_sl is high in any cycle.
- Completion:
  - doneN (owner only) pulses high for exactly 1 cycle, coincident with the last strobe cycle.
  - The next cycle is IDLE; a new grant is possible in that same IDLE cycle.
  - Back-to-back throughput is one command per L+1 cycles.
- busy=1 exactly in EXEC cycles.
- Down-counter: loaded with L-1 on handshake and decremented each EXEC cycle. Last cycle is when the counter equals 0. No wrap.
- A requester must hold vld and its fields until rdy; fields are sampled only at the handshake.

Optional Feature:
- Macro REG_OP_SEQUENCER_ABORT_EN.
- Defined:
  - Extra input port abort (1 bit).
  - abort=1 in an EXEC cycle makes that cycle's strobe the last one: owner done pulses that cycle and state returns to IDLE next.
  - abort in IDLE is ignored.
- Undefined: no abort port; every command runs its full L cycles.

Test Plan:
- Reset: rst=1 for 2 cycles with vld0=1 -> all outputs 0, rdy0=0 during reset; rdy0=1 first cycle after rst deasserts.
- Single INC: vld0, op=3, cnt=3, accepted at cycle T -> r_inc=1 at T+1..T+3, done0=1 at T+3, busy 0 at T+4, rdy0 again possible at T+4.
- LOAD then SHR: requester 1 LOAD dat=4'hA, then SHR cnt=2 sb=1 -> r_ld with r_in=A for one cycle, then r_sr=1, r_ir=1 for 2 cycles; done1 after each command; a model register reads A, D, E.
- Round-robin: vld0=vld1=1 continuously with CLR commands -> grants alternate 0,1,0,1 starting with 0 after reset; no requester is granted twice in a row.
- cnt=0 DEC and op=7 -> exactly one r_dec cycle; op 7 gives no strobe but done pulses after 1 cycle.
- With REG_OP_SEQUENCER_ABORT_EN: SHL cnt=7, abort at 3rd strobe cycle -> exactly 3 r_sl pulses, done0 on the 3rd. Reset asserted mid-command instead -> strobes drop to 0 next cycle, no done.

Source files
------------

// File: rtl/reg_op_sequencer.sv
// Round-robin sequencer that owns the control strobes of a shared 4-bit shift/count register.
// Optional mid-command abort input is enabled by defining REG_OP_SEQUENCER_ABORT_EN.
module reg_op_sequencer #(
  parameter int unsigned DW    = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld0,
  input  logic [2:0]       op0,
  input  logic [DW-1:0]    dat0,
  input  logic             sb0,
  input  logic [CNT_W-1:0] cnt0,
  output logic             rdy0,
  output logic             done0,
  input  logic             vld1,
  input  logic [2:0]       op1,
  input  logic [DW-1:0]    dat1,
  input  logic             sb1,
  input  logic [CNT_W-1:0] cnt1,
  output logic             rdy1,
  output logic             done1,
`ifdef REG_OP_SEQUENCER_ABORT_EN
  input  logic             abort,
`endif
  output logic             r_cl,
  output logic             r_ld,
  output logic [DW-1:0]    r_in,
  output logic             r_inc,
  output logic             r_dec,
  output logic             r_sr,
  output logic             r_ir,
  output logic             r_sl,
  output logic             r_il,
  output logic             busy
);

  localparam logic [2:0] OP_CLR  = 3'd1;
  localparam logic [2:0] OP_LOAD = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_SHL  = 3'd6;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           r_state;
  logic             r_rr;
  logic             r_own;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done0;
  logic             r_done1;

  logic             w_idle;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_hs;
  logic             w_sel;
  logic [2:0]       w_op;
  logic [DW-1:0]    w_dat;
  logic             w_sb;
  logic [CNT_W-1:0] w_cnt;
  logic             w_multi;
  logic [CNT_W-1:0] w_len_m1;
  logic             w_abort;
  logic             w_last;

`ifdef REG_OP_SEQUENCER_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Grant: a lone requester wins; on contention the rr pointer decides.
  assign w_idle  = (r_state == S_IDLE) && !rst;
  assign w_gnt0  = vld0 && (!vld1 || !r_rr);
  assign w_gnt1  = vld1 && (!vld0 || r_rr);
  assign rdy0    = w_idle && w_gnt0;
  assign rdy1    = w_idle && w_gnt1;
  assign w_hs    = w_idle && (vld0 || vld1);
  assign w_sel   = w_gnt1;

  assign w_op    = w_sel ? op1  : op0;
  assign w_dat   = w_sel ? dat1 : dat0;
  assign w_sb    = w_sel ? sb1  : sb0;
  assign w_cnt   = w_sel ? cnt1 : cnt0;

  // Only the counted ops repeat; a zero count still runs once.
  assign w_multi  = (w_op >= OP_INC) && (w_op <= OP_SHL);
  assign w_len_m1 = (w_multi && (w_cnt != '0)) ? (w_cnt - CNT_W'(1)) : '0;

  assign w_last  = (r_cnt == '0) || w_abort;
  assign done0   = r_done0 || (w_abort && busy && !r_own);
  assign done1   = r_done1 || (w_abort && busy && r_own);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_own   <= 1'b0;
      r_cnt   <= '0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_cl    <= 1'b0;
      r_ld    <= 1'b0;
      r_in    <= '0;
      r_inc   <= 1'b0;
      r_dec   <= 1'b0;
      r_sr    <= 1'b0;
      r_ir    <= 1'b0;
      r_sl    <= 1'b0;
      r_il    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_state <= S_EXEC;
            r_rr    <= !w_sel;
            r_own   <= w_sel;
            r_cnt   <= w_len_m1;
            r_done0 <= (w_len_m1 == '0) && !w_sel;
            r_done1 <= (w_len_m1 == '0) && w_sel;
            r_cl    <= (w_op == OP_CLR);
            r_ld    <= (w_op == OP_LOAD);
            r_in    <= (w_op == OP_LOAD) ? w_dat : '0;
            r_inc   <= (w_op == OP_INC);
            r_dec   <= (w_op == OP_DEC);
            r_sr    <= (w_op == OP_SHR);
            r_ir    <= (w_op == OP_SHR) && w_sb;
            r_sl    <= (w_op == OP_SHL);
            r_il    <= (w_op == OP_SHL) && w_sb;
            busy    <= 1'b1;
          end
        end
        S_EXEC: begin
          if (w_last) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_cl    <= 1'b0;
            r_ld    <= 1'b0;
            r_in    <= '0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_sr    <= 1'b0;
            r_ir    <= 1'b0;
            r_sl    <= 1'b0;
            r_il    <= 1'b0;
            busy    <= 1'b0;
          end else begin
            // Strobes hold; done is raised for the cycle where the count reaches zero.
            r_cnt   <= r_cnt - CNT_W'(1);
            r_done0 <= (r_cnt == CNT_W'(1)) && !r_own;
            r_done1 <= (r_cnt == CNT_W'(1)) && r_own;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
